// File: rtl/game_display_ctrl.sv
// Guessing-game display sequencer: takes guesses, counts trials and drives the 7-segment decoder controls.
// Optional macro GAME_BLINK_WIN_EN: blink the winning number using the SWITCH_TICKS divider.
module game_display_ctrl #(
    parameter int unsigned MAX_TRIALS   = 9,
    parameter int unsigned SWITCH_TICKS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        guess_valid,
    input  logic [15:0] guess,
    input  logic [15:0] secret,
    output logic [15:0] data,
    output logic [3:0]  cnt,
    output logic        en,
    output logic        count_over,
    output logic        state,
    output logic        switch,
    output logic        win,
    output logic        err
);

    localparam int unsigned DIV_W = (SWITCH_TICKS > 1) ? $clog2(SWITCH_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWITCH_TICKS - 1);
    localparam logic [3:0]       CNT_LAST = 4'(MAX_TRIALS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} fsm_t;

    fsm_t             fsm;
    logic [DIV_W-1:0] div;
    logic             guess_ok;
    logic             div_wrap;

    // A guess is legal only if every digit is a BCD value.
    assign guess_ok = (guess[15:12] <= 4'd9) && (guess[11:8] <= 4'd9) &&
                      (guess[7:4]   <= 4'd9) && (guess[3:0]  <= 4'd9);
    assign div_wrap = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            div        <= '0;
            data       <= '0;
            cnt        <= '0;
            en         <= 1'b0;
            count_over <= 1'b0;
            state      <= 1'b0;
            switch     <= 1'b0;
            win        <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            // start restarts from any state and drops a coincident guess
            if (start) begin
                fsm        <= PLAY;
                div        <= '0;
                data       <= '0;
                cnt        <= '0;
                en         <= 1'b0;
                count_over <= 1'b0;
                state      <= 1'b1;
                switch     <= 1'b0;
                win        <= 1'b0;
            end else begin
                case (fsm)
                    IDLE: begin
                    end
                    PLAY: begin
                        if (guess_valid) begin
                            if (!guess_ok) begin
                                err <= 1'b1;
                            end else begin
                                data <= guess;
                                cnt  <= cnt + 4'd1;
                                en   <= 1'b1;
                                // win is checked first so a correct final guess still wins
                                if (guess == secret) begin
                                    fsm <= WIN;
                                    win <= 1'b1;
                                    div <= '0;
                                end else if (cnt == CNT_LAST) begin
                                    fsm        <= LOSE;
                                    data       <= secret;
                                    count_over <= 1'b1;
                                    switch     <= 1'b0;
                                    div        <= '0;
                                end
                            end
                        end
                    end
                    WIN: begin
`ifdef GAME_BLINK_WIN_EN
                        if (tick) begin
                            if (div_wrap) begin
                                div <= '0;
                                en  <= ~en;
                            end else begin
                                div <= div + DIV_W'(1);
                            end
                        end
`endif
                    end
                    LOSE: begin
                        // alternate between secret and trial count
                        if (tick) begin
                            if (div_wrap) begin
                                div    <= '0;
                                switch <= ~switch;
                            end else begin
                                div <= div + DIV_W'(1);
                            end
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_display_ctrl.sv
// Scoreboard bench for game_display_ctrl: directed test-plan scenarios followed by randomized games.
module tb_game_display_ctrl;

    localparam int unsigned MAX_T = 3;
    localparam int unsigned ST    = 500;
`ifdef GAME_BLINK_WIN_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        guess_valid = 1'b0;
    logic [15:0] guess = '0;
    logic [15:0] secret = '0;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic        en, count_over, state, switch, win, err;

    always #5 clk = ~clk;

    game_display_ctrl #(.MAX_TRIALS(MAX_T), .SWITCH_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .guess_valid(guess_valid), .guess(guess), .secret(secret),
        .data(data), .cnt(cnt), .en(en), .count_over(count_over),
        .state(state), .switch(switch), .win(win), .err(err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  cnt;
        logic        en;
        logic        count_over;
        logic        state;
        logic        switch;
        logic        win;
        logic        err;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: game phase (0 idle, 1 play, 2 win, 3 lose) and ticks seen since win/lose entry.
    int          m_mode = 0;
    int          m_cnt = 0;
    int          m_ticks = 0;
    logic [15:0] m_data = '0;
    logic        m_en = 1'b0;
    logic        m_err = 1'b0;

    function automatic bit is_bad(input logic [15:0] g);
        for (int i = 0; i < 4; i++)
            if (((int'(g) >> (4 * i)) & 15) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit gv,
                                       input logic [15:0] g, input bit t, input logic [15:0] sec);
        if (r) begin
            m_mode = 0; m_cnt = 0; m_ticks = 0; m_data = '0; m_en = 1'b0; m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (s) begin
            m_mode = 1; m_cnt = 0; m_ticks = 0; m_data = '0; m_en = 1'b0;
        end else if (m_mode == 1) begin
            if (gv) begin
                if (is_bad(g)) m_err = 1'b1;
                else begin
                    m_data = g; m_cnt = m_cnt + 1; m_en = 1'b1;
                    if (g == sec) begin
                        m_mode = 2; m_ticks = 0;
                    end else if (m_cnt == int'(MAX_T)) begin
                        m_mode = 3; m_ticks = 0; m_data = sec;
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (BLINK && t) m_ticks++;
        end else if (m_mode == 3) begin
            if (t) m_ticks++;
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.data       = m_data;
        o.cnt        = 4'(m_cnt);
        o.err        = m_err;
        o.state      = (m_mode != 0);
        o.win        = (m_mode == 2);
        o.count_over = (m_mode == 3);
        o.switch     = (m_mode == 3) && (((m_ticks / int'(ST)) % 2) == 1);
        if (m_mode == 2) o.en = BLINK ? (((m_ticks / int'(ST)) % 2) == 0) : 1'b1;
        else             o.en = m_en;
        return o;
    endfunction

    // Monitor: the DUT presents a fresh output word every cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{data, cnt, en, count_over, state, switch, win, err};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got %h required %h", $time, mon_a, mon_e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, expv);
        end
    endtask

    task automatic cyc(input bit s, input bit gv, input logic [15:0] g, input bit t);
        @(negedge clk);
        rst = 1'b0; start = s; guess_valid = gv; guess = g; tick = t;
        model_step(1'b0, s, gv, g, t, secret);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; guess_valid = 1'b0; tick = 1'b0;
        #1;
        chk("async_rst", {data, cnt, en, count_over, state, switch, win, err}, 32'h0);
        model_step(1'b1, 1'b0, 1'b0, '0, 1'b0, secret);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        logic [15:0] g;
        int          p;
        bit          s, gv;

        #3;
        rst_cyc();
        rst_cyc();
        chk("reset_state", 32'(state), 32'h0);

        // first guess shows on the display
        secret = 16'h5678;
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("g1_data", 32'(data), 32'h1234);
        chk("g1_cnt", 32'(cnt), 32'd1);
        chk("g1_en", 32'(en), 32'd1);
        chk("g1_state", 32'(state), 32'd1);
        chk("g1_win", 32'(win), 32'd0);

        // out of trials: secret shown, switch alternates every ST ticks
        cyc(1'b0, 1'b1, 16'h1111, 1'b0);
        cyc(1'b0, 1'b1, 16'h2222, 1'b0);
        chk("lose_over", 32'(count_over), 32'd1);
        chk("lose_data", 32'(data), 32'h5678);
        chk("lose_cnt", 32'(cnt), 32'd3);
        chk("lose_sw0", 32'(switch), 32'd0);
        ticks(ST - 1);
        chk("lose_sw_early", 32'(switch), 32'd0);
        ticks(1);
        chk("lose_sw500", 32'(switch), 32'd1);
        ticks(ST);
        chk("lose_sw1000", 32'(switch), 32'd0);
        ticks(ST);
        chk("lose_sw1500", 32'(switch), 32'd1);
        rst_cyc();
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("restart_cnt", 32'(cnt), 32'd0);
        chk("restart_state", 32'(state), 32'd1);

        // rejected guess and start/guess collision
        secret = 16'h0042;
        cyc(1'b0, 1'b1, 16'h0555, 1'b0);
        cyc(1'b0, 1'b1, 16'h12A4, 1'b0);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_cnt", 32'(cnt), 32'd1);
        chk("bad_data", 32'(data), 32'h0555);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("bad_err_once", 32'(err), 32'd0);
        cyc(1'b1, 1'b1, 16'h0042, 1'b0);
        chk("collide_cnt", 32'(cnt), 32'd0);
        chk("collide_en", 32'(en), 32'd0);
        chk("collide_win", 32'(win), 32'd0);

        // correct guess on the final trial wins
        cyc(1'b0, 1'b1, 16'h1111, 1'b0);
        cyc(1'b0, 1'b1, 16'h2222, 1'b0);
        cyc(1'b0, 1'b1, 16'h0042, 1'b0);
        chk("win_win", 32'(win), 32'd1);
        chk("win_data", 32'(data), 32'h0042);
        chk("win_over", 32'(count_over), 32'd0);
        chk("win_cnt", 32'(cnt), 32'd3);
        ticks(ST);
        chk("win_en500", 32'(en), BLINK ? 32'd0 : 32'd1);
        ticks(ST);
        chk("win_en1000", 32'(en), 32'd1);

        // randomized games
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                rst_cyc();
                continue;
            end
            if ($urandom_range(0, 49) == 0) secret = rand_bcd();
            if (m_mode == 0)      s = ($urandom_range(0, 9) == 0);
            else if (m_mode == 1) s = ($urandom_range(0, 99) == 0);
            else                  s = ($urandom_range(0, 999) == 0);
            gv = ($urandom_range(0, 9) < 4);
            p  = $urandom_range(0, 99);
            if (p < 25) g = secret;
            else begin
                g = rand_bcd();
                if (p < 40) g[4 * $urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            end
            cyc(s, gv, g, ($urandom_range(0, 4) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_display_ctrl.md
# game_display_ctrl

Sequencer for the four-digit guessing-game display driver. Accepts player guesses, counts trials, compares each guess against the secret, and produces the `data`, `cnt`, `en`, `count_over`, `state` and `switch` controls consumed by the 7-segment decoder. In the lose state it alternates the display between the secret and the trial count. Sits between the keypad/guess-entry logic and the BCD-to-7-segment decoder.

## Interface
- `MAX_TRIALS`, default 9: guesses allowed before loss; legal range 1..15.
- `SWITCH_TICKS`, default 500: `tick` pulses per `switch` half-period in LOSE; legal range ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  single-cycle timebase strobe, nominally 1 kHz.
- `start`  in  1  single-cycle pulse; begins a new game from any state.
- `guess_valid`  in  1  single-cycle strobe qualifying `guess`.
- `guess`  in  16  four BCD digits; [15:12] is the most significant digit.
- `secret`  in  16  four BCD digits; sampled on every compare.
- `data`  out  16  BCD digits to display.
- `cnt`  out  4  trials used.
- `en`  out  1  display enable.
- `count_over`  out  1  high in LOSE.
- `state`  out  1  0 in IDLE, 1 otherwise.
- `switch`  out  1  LOSE alternation: 0 shows `data`, 1 shows `cnt`.
- `win`  out  1  high in WIN.
- `err`  out  1  one-cycle pulse when a guess is rejected.

## Operation
- FSM states: IDLE, PLAY, WIN, LOSE. All outputs are registered.
- Reset: FSM goes to IDLE. `data`=0, `cnt`=0, `en`=0, `count_over`=0, `state`=0, `switch`=0, `win`=0, `err`=0. The tick divider clears.
- IDLE: display is blank. `start` moves to PLAY.
- Entering PLAY (from any state): `cnt`=0, `data`=0, `en`=0, `switch`=0, `count_over`=0, `win`=0.
- PLAY, on `guess_valid`:
  - If any nibble of `guess` is greater than 9: pulse `err` for one cycle. No other change.
  - Otherwise: `data`←`guess`, `cnt`←`cnt`+1, `en`←1.
  - Then, if `guess`==`secret`, go to WIN.
  - Else, if `cnt`+1==`MAX_TRIALS`, go to LOSE.
  - Else, stay in PLAY.
- WIN: `win`=1, `en`=1, `data` holds the winning guess.
- LOSE entry: `data`←`secret`, `count_over`=1, `switch`=0, tick divider cleared.
- LOSE: `switch` toggles after every `SWITCH_TICKS` `tick` pulses. `cnt` holds `MAX_TRIALS`.
- `guess_valid` is ignored outside PLAY; `err` does not pulse.
- `start` in WIN, LOSE or PLAY restarts the game. PLAY entry values apply.
- `start` together with `guess_valid` in the same cycle: `start` wins and the guess is dropped; `cnt` stays 0.
- A correct guess on the final trial goes to WIN. Win takes precedence over lose.
- `tick` outside LOSE has no effect.

## Timing
- `guess_valid` in cycle N: `data`, `cnt`, `en`, `err` and the new FSM state are visible in cycle N+1.
- `start` in cycle N: PLAY outputs are visible in cycle N+1.
- `switch` toggles in the cycle after the `SWITCH_TICKS`-th `tick` since LOSE entry or since the previous toggle.
- Asserting `rst` at any point, including mid-game or mid-LOSE, forces the reset values immediately. These hold until the first rising edge after release.
- Back-to-back `guess_valid` strobes in consecutive cycles are each accepted.

## Configuration
- `GAME_BLINK_WIN_EN` defined: in WIN, `en` toggles after every `SWITCH_TICKS` `tick` pulses, starting at 1 on entry, so the winning number blinks.
- `GAME_BLINK_WIN_EN` undefined: `en` is held at 1 in WIN. No divider activity occurs in WIN.

## Test plan
- Reset, then `start`, then guess 0x1234 with secret 0x5678 → next cycle `data`=0x1234, `cnt`=1, `en`=1, `state`=1, `win`=0.
- `MAX_TRIALS`=3, three wrong guesses → after the third: `count_over`=1, `data`=`secret`, `cnt`=3, `switch`=0. After 500 `tick` pulses `switch`=1; after 1000, `switch`=0.
- `MAX_TRIALS`=3, third guess equals `secret` (0x0042) → WIN, `win`=1, `data`=0x0042, `count_over`=0.
- Guess 0x12A4 in PLAY → `err` high for exactly one cycle, `cnt` and `data` unchanged. `start` and `guess_valid` in the same cycle → `cnt`=0, `en`=0.
- `rst` asserted mid-LOSE while `switch`=1 → all outputs return to reset values asynchronously. A subsequent `start` gives `cnt`=0, `state`=1.
- With `GAME_BLINK_WIN_EN` defined, a correct guess followed by 500 `tick` pulses → `en`=0. After 500 more → `en`=1. Without the macro, `en` stays 1.
